// File: rtl/mtm_alu_deserializer.sv
// Serial front end of the mtm_Alu: assembles 11-bit packets into 8 DATA + 1 CTL frames,
// checks count/CRC/opcode. Optional inter-packet timeout: define DESER_TIMEOUT_EN.
module mtm_alu_deserializer #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  output logic        cmd_valid,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [2:0]  op,
  output logic        err_valid,
  output logic [2:0]  err_flags
);

  typedef enum logic [1:0] {StIdle, StType, StData, StStop} bit_state_e;

  bit_state_e  state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        is_ctl_q, is_ctl_d;
  logic [7:0]  sh_q, sh_d;
  logic [63:0] frame_q, frame_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        bad_q, bad_d;
  logic [3:0]  crc_q, crc_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [2:0]  op_q, op_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic        err_valid_q, err_valid_d;
  logic [2:0]  err_flags_q, err_flags_d;
  logic [3:0]  crc_full;

  // Direct-form step: equals the augmented (msg * x^4) mod g without feeding trailing zeros.
  function automatic logic [3:0] crc_step(input logic [3:0] c, input logic b);
    logic fb;
    fb = c[3] ^ b;
    return {c[2:0], 1'b0} ^ (fb ? 4'h3 : 4'h0);
  endfunction

  // Finish the CRC over the trailing {1'b1, op} carried in the CTL byte.
  assign crc_full = crc_step(crc_step(crc_step(crc_step(crc_q, 1'b1), sh_q[6]), sh_q[5]),
                             sh_q[4]);

`ifdef DESER_TIMEOUT_EN
  localparam int unsigned IdleW = $clog2(TIMEOUT_CYCLES + 1);
  logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    is_ctl_d    = is_ctl_q;
    sh_d        = sh_q;
    frame_d     = frame_q;
    cnt_d       = cnt_q;
    bad_d       = bad_q;
    crc_d       = crc_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    cmd_valid_d = 1'b0;
    err_valid_d = 1'b0;
    err_flags_d = err_flags_q;
`ifdef DESER_TIMEOUT_EN
    idle_cnt_d  = '0;
`endif

    unique case (state_q)
      StIdle: begin
        if (!sin) begin
          state_d = StType;
        end
`ifdef DESER_TIMEOUT_EN
        else if (cnt_q != 4'd0) begin
          if (idle_cnt_q == IdleW'(TIMEOUT_CYCLES - 1)) begin
            cnt_d       = 4'd0;
            bad_d       = 1'b0;
            crc_d       = 4'd0;
            err_valid_d = 1'b1;
            err_flags_d = 3'b100;
          end else begin
            idle_cnt_d = idle_cnt_q + IdleW'(1);
          end
        end
`endif
      end
      StType: begin
        is_ctl_d  = sin;
        bit_cnt_d = 3'd0;
        state_d   = StData;
      end
      StData: begin
        sh_d      = {sh_q[6:0], sin};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (!is_ctl_q && cnt_q < 4'd8) begin
          crc_d = crc_step(crc_q, sin);
        end
        if (bit_cnt_q == 3'd7) begin
          state_d = StStop;
        end
      end
      StStop: begin
        state_d = StIdle;
        if (!sin) begin
          bad_d = 1'b1;
        end else if (!is_ctl_q) begin
          if (cnt_q < 4'd8) begin
            frame_d = {frame_q[55:0], sh_q};
            cnt_d   = cnt_q + 4'd1;
          end else begin
            cnt_d = 4'd9;
            bad_d = 1'b1;
          end
        end else begin
          if (cnt_q != 4'd8 || bad_q) begin
            err_valid_d = 1'b1;
            err_flags_d = 3'b100;
          end else if (crc_full != sh_q[3:0]) begin
            err_valid_d = 1'b1;
            err_flags_d = 3'b010;
          end else if (sh_q[7] || sh_q[5]) begin
            // Legal opcodes all have op[1] == 0.
            err_valid_d = 1'b1;
            err_flags_d = 3'b001;
          end else begin
            cmd_valid_d = 1'b1;
            b_d         = frame_q[63:32];
            a_d         = frame_q[31:0];
            op_d        = sh_q[6:4];
          end
          cnt_d = 4'd0;
          bad_d = 1'b0;
          crc_d = 4'd0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      bit_cnt_q   <= 3'd0;
      is_ctl_q    <= 1'b0;
      sh_q        <= 8'd0;
      frame_q     <= 64'd0;
      cnt_q       <= 4'd0;
      bad_q       <= 1'b0;
      crc_q       <= 4'd0;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      op_q        <= 3'd0;
      cmd_valid_q <= 1'b0;
      err_valid_q <= 1'b0;
      err_flags_q <= 3'd0;
`ifdef DESER_TIMEOUT_EN
      idle_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      is_ctl_q    <= is_ctl_d;
      sh_q        <= sh_d;
      frame_q     <= frame_d;
      cnt_q       <= cnt_d;
      bad_q       <= bad_d;
      crc_q       <= crc_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      cmd_valid_q <= cmd_valid_d;
      err_valid_q <= err_valid_d;
      err_flags_q <= err_flags_d;
`ifdef DESER_TIMEOUT_EN
      idle_cnt_q  <= idle_cnt_d;
`endif
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign err_valid = err_valid_q;
  assign err_flags = err_flags_q;
  assign A         = a_q;
  assign B         = b_q;
  assign op        = op_q;

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// Directed bench for mtm_alu_deserializer; timeout scenario runs when DESER_TIMEOUT_EN is defined.
module tb_mtm_alu_deserializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        sin = 1'b1;
  logic        cmd_valid, err_valid;
  logic [31:0] A, B;
  logic [2:0]  op, err_flags;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_cmd = 0;
  int n_err = 0;
  int n_both = 0;

  mtm_alu_deserializer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sin       (sin),
    .cmd_valid (cmd_valid),
    .A         (A),
    .B         (B),
    .op        (op),
    .err_valid (err_valid),
    .err_flags (err_flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cmd_valid === 1'b1) n_cmd++;
    if (err_valid === 1'b1) n_err++;
    if (cmd_valid === 1'b1 && err_valid === 1'b1) n_both++;
  end

  // Long-division reference: remainder of ({B, A, 1, op} * x^4) mod (x^4 + x + 1).
  function automatic logic [3:0] crc_model(input logic [31:0] b, input logic [31:0] a,
                                           input logic [2:0] o);
    logic [71:0] r;
    r = {b, a, 1'b1, o, 4'b0000};
    for (int i = 71; i >= 4; i--) begin
      if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
    end
    return r[3:0];
  endfunction

  task automatic send_bit(input logic b);
    sin = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input logic typ, input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    send_bit(typ);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_pkt(1'b0, w[8*i +: 8], 1'b1);
  endtask

  task automatic send_frame(input logic [31:0] b, input logic [31:0] a, input logic [7:0] ctl);
    send_word(b);
    send_word(a);
    send_pkt(1'b1, ctl, 1'b1);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({cmd_valid, err_valid, A, B, op, err_flags} !== 72'd0) begin
      errors++;
      $display("FAIL reset_outputs got cv=%b ev=%b A=%h B=%h op=%b ef=%b want all 0",
               cmd_valid, err_valid, A, B, op, err_flags);
    end
    rst_n = 1'b1;
    send_bit(1'b1);
    send_bit(1'b1);
  endtask

  task automatic test_zero_cmd();
    send_frame(32'd0, 32'd0, 8'h0B);
    checks++;
    if (cmd_valid !== 1'b1 || err_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_pulse got cv=%b ev=%b want cv=1 ev=0", cmd_valid, err_valid);
    end
    checks++;
    if ({A, B, op} !== 67'd0) begin
      errors++;
      $display("FAIL zero_data got A=%h B=%h op=%b want 0", A, B, op);
    end
    send_bit(1'b1);
    checks++;
    if (cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_pulse_width got cv=%b want 0", cmd_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ctl;
    int t1, t2;
    ctl = {1'b0, 3'b100, crc_model(32'd3, 32'd5, 3'b100)};
    send_frame(32'd3, 32'd5, ctl);
    t1 = cyc;
    checks++;
    if (cmd_valid !== 1'b1 || A !== 32'd5 || B !== 32'd3 || op !== 3'b100) begin
      errors++;
      $display("FAIL add_cmd got cv=%b A=%h B=%h op=%b want cv=1 A=5 B=3 op=100",
               cmd_valid, A, B, op);
    end
    send_frame(32'd3, 32'd5, ctl);
    t2 = cyc;
    checks++;
    if (cmd_valid !== 1'b1 || t2 - t1 != 99) begin
      errors++;
      $display("FAIL b2b_spacing got cv=%b gap=%0d want cv=1 gap=99", cmd_valid, t2 - t1);
    end
  endtask

  task automatic test_crc_err();
    send_frame(32'd0, 32'd0, 8'h0A);
    checks++;
    if (err_valid !== 1'b1 || err_flags !== 3'b010 || cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL crc_err got ev=%b ef=%b cv=%b want ev=1 ef=010 cv=0",
               err_valid, err_flags, cmd_valid);
    end
    checks++;
    if (A !== 32'd5 || B !== 32'd3 || op !== 3'b100) begin
      errors++;
      $display("FAIL crc_err_hold got A=%h B=%h op=%b want A=5 B=3 op=100", A, B, op);
    end
    send_bit(1'b1);
    checks++;
    if (err_valid !== 1'b0 || err_flags !== 3'b010) begin
      errors++;
      $display("FAIL crc_err_after got ev=%b ef=%b want ev=0 ef=010", err_valid, err_flags);
    end
  endtask

  task automatic test_data_count();
    send_word(32'd0);
    for (int i = 0; i < 3; i++) send_pkt(1'b0, 8'h00, 1'b1);
    send_pkt(1'b1, 8'h0B, 1'b1);
    checks++;
    if (err_valid !== 1'b1 || err_flags !== 3'b100) begin
      errors++;
      $display("FAIL count7 got ev=%b ef=%b want ev=1 ef=100", err_valid, err_flags);
    end
    send_word(32'd0);
    send_word(32'd0);
    send_pkt(1'b0, 8'h00, 1'b1);
    send_pkt(1'b1, 8'h0B, 1'b1);
    checks++;
    if (err_valid !== 1'b1 || err_flags !== 3'b100) begin
      errors++;
      $display("FAIL count9 got ev=%b ef=%b want ev=1 ef=100", err_valid, err_flags);
    end
    send_frame(32'd0, 32'd0, 8'h0B);
    checks++;
    if (cmd_valid !== 1'b1 || err_valid !== 1'b0 || {A, B, op} !== 67'd0) begin
      errors++;
      $display("FAIL count_recover got cv=%b ev=%b A=%h B=%h op=%b want cv=1 ev=0 zeros",
               cmd_valid, err_valid, A, B, op);
    end
  endtask

  task automatic test_opcode();
    logic [7:0] ctl;
    ctl = {1'b0, 3'b010, crc_model(32'h1122_3344, 32'h5566_7788, 3'b010)};
    send_frame(32'h1122_3344, 32'h5566_7788, ctl);
    checks++;
    if (err_valid !== 1'b1 || err_flags !== 3'b001 || cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL op010 got ev=%b ef=%b cv=%b want ev=1 ef=001 cv=0",
               err_valid, err_flags, cmd_valid);
    end
    send_frame(32'd0, 32'd0, 8'h8B);
    checks++;
    if (err_valid !== 1'b1 || err_flags !== 3'b001 || cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL ctl_bit7 got ev=%b ef=%b cv=%b want ev=1 ef=001 cv=0",
               err_valid, err_flags, cmd_valid);
    end
  endtask

  task automatic test_bad_stop();
    logic [7:0] ctl;
    ctl = {1'b0, 3'b000, crc_model(32'hA1B2_C3D4, 32'd7, 3'b000)};
    send_pkt(1'b0, 8'hA1, 1'b1);
    send_pkt(1'b0, 8'hB2, 1'b1);
    send_pkt(1'b0, 8'hC3, 1'b1);
    send_pkt(1'b0, 8'hD4, 1'b0);
    send_bit(1'b1);
    send_word(32'd7);
    send_pkt(1'b1, ctl, 1'b1);
    checks++;
    if (err_valid !== 1'b1 || err_flags !== 3'b100 || cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL bad_stop got ev=%b ef=%b cv=%b want ev=1 ef=100 cv=0",
               err_valid, err_flags, cmd_valid);
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] ctl;
    int snap_cmd, snap_err;
    send_word(32'hCAFE_F00D);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({cmd_valid, err_valid, A, B, op, err_flags} !== 72'd0) begin
      errors++;
      $display("FAIL midreset_outputs got A=%h B=%h op=%b ef=%b want all 0", A, B, op,
               err_flags);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    snap_cmd = n_cmd;
    snap_err = n_err;
    send_bit(1'b1);
    send_bit(1'b1);
    ctl = {1'b0, 3'b001, crc_model(32'hDEAD_BEEF, 32'h1234_5678, 3'b001)};
    send_frame(32'hDEAD_BEEF, 32'h1234_5678, ctl);
    checks++;
    if (cmd_valid !== 1'b1 || A !== 32'h1234_5678 || B !== 32'hDEAD_BEEF || op !== 3'b001) begin
      errors++;
      $display("FAIL midreset_cmd got cv=%b A=%h B=%h op=%b want cv=1 A=12345678 B=deadbeef op=001",
               cmd_valid, A, B, op);
    end
    send_bit(1'b1);
    checks++;
    if (n_cmd != snap_cmd + 1 || n_err != snap_err) begin
      errors++;
      $display("FAIL midreset_pulses got cmd=%0d err=%0d want cmd=%0d err=%0d",
               n_cmd - snap_cmd, n_err - snap_err, 1, 0);
    end
  endtask

`ifdef DESER_TIMEOUT_EN
  task automatic test_timeout();
    int early;
    early = 0;
    send_word(32'h0102_0304);
    for (int i = 0; i < 63; i++) begin
      send_bit(1'b1);
      if (err_valid === 1'b1) early++;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL timeout_early got %0d early pulses want 0", early);
    end
    send_bit(1'b1);
    checks++;
    if (err_valid !== 1'b1 || err_flags !== 3'b100) begin
      errors++;
      $display("FAIL timeout_err got ev=%b ef=%b want ev=1 ef=100", err_valid, err_flags);
    end
    send_frame(32'd0, 32'd0, 8'h0B);
    checks++;
    if (cmd_valid !== 1'b1) begin
      errors++;
      $display("FAIL timeout_recover got cv=%b want 1", cmd_valid);
    end
  endtask
`endif

  initial begin
    int exp_cmd, exp_err;
    exp_cmd = 5;
    exp_err = 6;
    test_reset();
    test_zero_cmd();
    test_back_to_back();
    test_crc_err();
    test_data_count();
    test_opcode();
    test_bad_stop();
    test_mid_reset();
`ifdef DESER_TIMEOUT_EN
    test_timeout();
    exp_cmd = exp_cmd + 1;
    exp_err = exp_err + 1;
`endif
    send_bit(1'b1);
    checks++;
    if (n_both != 0) begin
      errors++;
      $display("FAIL both_pulses got %0d overlapping cycles want 0", n_both);
    end
    checks++;
    if (n_cmd != exp_cmd || n_err != exp_err) begin
      errors++;
      $display("FAIL pulse_totals got cmd=%0d err=%0d want cmd=%0d err=%0d",
               n_cmd, n_err, exp_cmd, exp_err);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got no completion want finish before 1ms");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mtm_alu_deserializer.md
Name: mtm_alu_deserializer

Overview:
- Serial input front end of the mtm_Alu. Samples `sin` one bit per `clk` and assembles 11-bit packets into a command frame: 8 DATA bytes plus 1 CTL byte.
- Checks each frame for data count, CRC and opcode validity.
- Presents either a validated {A, B, op} command or an error code to the ALU core. It is the receiving end of the serial frames the bench tester transmits.

Parameters:
- TIMEOUT_CYCLES, 64, idle `clk` cycles allowed between packets inside a frame (used only with the optional feature).

Ports:
- clk  in  1  system clock; `sin` sampled on rising edge
- rst_n  in  1  asynchronous active-low reset
- sin  in  1  serial input; idles high
- cmd_valid  out  1  one-cycle pulse: A, B, op hold a validated command
- A  out  32  operand A
- B  out  32  operand B
- op  out  3  opcode: AND=000, OR=001, ADD=100, SUB=101
- err_valid  out  1  one-cycle pulse: err_flags valid
- err_flags  out  3  {ERR_DATA, ERR_CRC, ERR_OP}; exactly one bit set when err_valid is high

Behaviour:
- Reset: clock is one; reset is asynchronous and active-low. While `rst_n`=0, all outputs are 0, both FSMs are in IDLE, byte count is 0, and the shift registers are cleared. Asserting reset mid-packet abandons the frame silently.
- Packet format, sampled one bit per clock: start (0), type (0=DATA, 1=CTL), d[7:0] MSB first, stop (1). 11 cycles per packet.
- Bit FSM:
  - IDLE → TYPE when `sin`=0.
  - TYPE → DATA, capturing the type bit.
  - DATA: 8 cycles, shifting the byte in.
  - DATA → STOP.
  - STOP → IDLE.
  - Back-to-back packets are legal: a start bit may arrive in the cycle right after the stop bit.
- Stop bit sampled as 0: the byte is discarded, the frame is marked bad, and the bit FSM returns to IDLE.
- Frame handling:
  - DATA bytes 0–3 fill B[31:24] down to B[7:0].
  - DATA bytes 4–7 fill A[31:24] down to A[7:0].
  - Byte count saturates at 9; bytes beyond the eighth are dropped and mark the frame bad.
- CTL byte = {1'b0, op[2:0], crc[3:0]}. On its stop bit, checks run in priority order:
  1. Count ≠ 8 or frame bad → ERR_DATA.
  2. CRC mismatch → ERR_CRC.
  3. Opcode not in {000, 001, 100, 101} → ERR_OP.
  4. Otherwise a valid command.
- CRC definition: CRC-4, polynomial x^4+x+1, init 0. Computed over the 68 bits {B, A, 1'b1, op}, MSB first, augmented, i.e. (msg·x^4) mod g. The CRC is accumulated serially as DATA bits arrive; no 68-bit buffer.
- Output latency: `cmd_valid` or `err_valid` pulses exactly 1 cycle after the CTL stop bit is sampled.
  - A, B and op are registered and hold until the next cmd_valid.
  - err_flags holds until the next err_valid.
  - cmd_valid and err_valid are never high together.
- After any CTL byte (valid or error), the byte count clears and the frame-bad flag clears. The next frame starts fresh.
- CTL byte with bit 7 = 1 is treated as an invalid opcode → ERR_OP, if the count and CRC checks passed.
- Start bit during a pulse cycle is accepted normally; reception continues.

Optional Feature:
- Macro: DESER_TIMEOUT_EN.
- Defined:
  - An idle counter runs in bit-FSM IDLE while byte count > 0.
  - On reaching TIMEOUT_CYCLES, the frame is dropped, count clears, and err_valid pulses with err_flags=3'b100 (ERR_DATA) one cycle later.
  - The counter resets on each start bit.
- Undefined: no counter is instantiated. A partial frame waits indefinitely for more packets.

Test Plan:
- Valid all-zero command: B=0, A=0, then CTL 8'h0B (op=AND, crc=4'b1011) → cmd_valid 1 cycle after stop; A=0, B=0, op=000.
- Valid data: B=32'h0000_0003, A=32'h0000_0005, op=ADD, correct CRC from the bench model → cmd_valid; A=5, B=3, op=100. Repeat back-to-back with zero idle gap → second cmd_valid exactly 99 cycles after the first.
- Same frame as the all-zero case with CTL 8'h0A → err_valid, err_flags=3'b010; no cmd_valid.
- 7 DATA bytes then CTL; separately 9 DATA bytes then CTL → err_flags=3'b100 in both cases; the following valid frame is accepted normally.
- Valid CRC with op=3'b010 → err_flags=3'b001. Stop bit forced to 0 on DATA byte 3 → err_flags=3'b100 at CTL.
- rst_n pulsed low mid-DATA-byte, then a full valid frame → no output for the aborted frame; the new frame gives cmd_valid. With DESER_TIMEOUT_EN and TIMEOUT_CYCLES=64: 4 DATA bytes then idle → err_flags=3'b100 after 64 idle cycles.
